pipelined_adder: RTL and testbench

//   Parametrised N-bit add/subtract unit, carry chain split into STAGES registered slices.

---
 rtl/adder_pkg.sv | 12 +
 rtl/adder_slice.sv | 26 ++
 rtl/pipelined_adder.sv | 115 +++++++++++
 tb/tb_pipelined_adder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared add/subtract mode constants and signed-overflow helper
package adder_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Overflow occurs when both addends share a sign and the result sign differs from it.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - combinational W-bit ripple-carry adder slice
module adder_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] w_carry;

    always_comb begin
        w_carry    = '0;
        sum        = '0;
        w_carry[0] = cin;
        for (int i = 0; i < W; i++) begin
            sum[i]         = a[i] ^ b[i] ^ w_carry[i];
            w_carry[i + 1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = w_carry[W];

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - WIDTH-bit add/subtract with the carry chain split across STAGES registered slices
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam logic [WIDTH-1:0] LOW_MASK = (WIDTH'(1) << CHUNK) - WIDTH'(1);

    if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
        $error("pipelined_adder: STAGES must be within 1..WIDTH");
    end
    if (WIDTH % STAGES != 0) begin : g_bad_width
        $error("pipelined_adder: WIDTH must be an exact multiple of STAGES");
    end

    logic [WIDTH-1:0] r_a     [STAGES];
    logic [WIDTH-1:0] r_b     [STAGES];
    logic [WIDTH-1:0] r_sum   [STAGES];
    logic             r_carry [STAGES];
    logic [STAGES-1:0] r_valid;
    logic             r_ovf;

    logic [WIDTH-1:0] w_a_in       [STAGES];
    logic [WIDTH-1:0] w_b_in       [STAGES];
    logic [WIDTH-1:0] w_sum_in     [STAGES];
    logic             w_c_in       [STAGES];
    logic [CHUNK-1:0] w_slice_sum  [STAGES];
    logic             w_slice_cout [STAGES];
    logic [WIDTH-1:0] w_sum_next   [STAGES];
    logic [STAGES-1:0] w_v_in;
    logic             w_adv;

    // One global advance: the whole pipe moves unless a held result is being refused.
    assign w_adv    = !r_valid[STAGES-1] || out_ready;
    assign in_ready = w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] SLICE_MASK = LOW_MASK << (k * CHUNK);

        if (k == 0) begin : g_entry
            // Subtract is folded in here so later stages only ever add.
            assign w_a_in[0]   = a;
            assign w_b_in[0]   = (sub == MODE_SUB) ? ~b : b;
            assign w_c_in[0]   = (sub == MODE_SUB) ? 1'b1 : cin;
            assign w_sum_in[0] = '0;
            assign w_v_in[0]   = in_valid;
        end else begin : g_chain
            assign w_a_in[k]   = r_a[k-1];
            assign w_b_in[k]   = r_b[k-1];
            assign w_c_in[k]   = r_carry[k-1];
            assign w_sum_in[k] = r_sum[k-1];
            assign w_v_in[k]   = r_valid[k-1];
        end

        adder_slice #(
            .W(CHUNK)
        ) u_slice (
            .a   (w_a_in[k][k*CHUNK +: CHUNK]),
            .b   (w_b_in[k][k*CHUNK +: CHUNK]),
            .cin (w_c_in[k]),
            .sum (w_slice_sum[k]),
            .cout(w_slice_cout[k])
        );

        assign w_sum_next[k] = (w_sum_in[k] & ~SLICE_MASK)
                             | (WIDTH'(w_slice_sum[k]) << (k * CHUNK));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_ovf   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]     <= '0;
                r_b[k]     <= '0;
                r_sum[k]   <= '0;
                r_carry[k] <= 1'b0;
            end
        end else if (w_adv) begin
            r_valid <= w_v_in;
            r_ovf   <= signed_ovf(w_a_in[STAGES-1][WIDTH-1],
                                  w_b_in[STAGES-1][WIDTH-1],
                                  w_sum_next[STAGES-1][WIDTH-1]);
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]     <= w_a_in[k];
                r_b[k]     <= w_b_in[k];
                r_sum[k]   <= w_sum_next[k];
                r_carry[k] <= w_slice_cout[k];
            end
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign sum       = r_sum[STAGES-1];
    assign cout      = r_carry[STAGES-1];
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - self-checking bench for pipelined_adder (WIDTH=32, STAGES=4)
module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipelined_adder #(
        .WIDTH (32),
        .STAGES(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: wide signed/unsigned arithmetic, result packed as {ovf, cout, sum}.
    function automatic logic [33:0] ref_op(input logic [31:0] x, input logic [31:0] y,
                                           input logic ci, input logic s);
        logic signed [33:0] sx;
        logic signed [33:0] sy;
        logic signed [33:0] res;
        logic [32:0]        u;
        logic               c;
        logic               o;
        sx = {{2{x[31]}}, x};
        sy = {{2{y[31]}}, y};
        if (s) begin
            res = sx - sy;
            u   = {1'b0, x} - {1'b0, y};
            c   = (x >= y);
        end else begin
            res = sx + sy + {33'b0, ci};
            u   = {1'b0, x} + {1'b0, y} + {32'b0, ci};
            c   = u[32];
        end
        o = (res > 34'sh0_7FFF_FFFF) || (res < -34'sh0_8000_0000);
        return {o, c, u[31:0]};
    endfunction

    task automatic single_op(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                             input logic xc, input logic xs,
                             input logic [31:0] es, input logic ec, input logic eo);
        int lat;
        a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd4);
        check({tag, " sum"}, 64'(sum), 64'(es));
        check({tag, " cout"}, 64'(cout), 64'(ec));
        check({tag, " ovf"}, 64'(ovf), 64'(eo));
        @(posedge clk); #1;
    endtask

    // Streams n_ops operands; out_ready is low on cycles stall_lo..stall_hi, or random when rnd=1.
    task automatic run_stream(input string tag, input int n_ops, input int stall_lo,
                              input int stall_hi, input bit rnd, input int exp_cycles);
        logic [33:0] exp_q[$];
        logic [33:0] held;
        logic [33:0] exp_r;
        bit          stalled_prev = 1'b0;
        int          sent = 0;
        int          got = 0;
        int          cyc = 0;
        while ((sent < n_ops || got < n_ops) && cyc < n_ops * 8 + 50) begin
            @(posedge clk); #1;
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= stall_lo && cyc <= stall_hi);
            if (sent < n_ops && (!rnd || $urandom_range(0, 4) != 0)) begin
                in_valid = 1'b1;
                if (rnd) begin
                    a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
                end else begin
                    a = 32'h1357_9BDF * (sent + 1); b = 32'h0F0F_00FF + 32'(sent) * 32'h0100_0001;
                    cin = sent[0]; sub = sent[1];
                end
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!rnd) check({tag, " in_ready"}, 64'(in_ready), 64'(!(cyc >= stall_lo && cyc <= stall_hi)));
            if (stalled_prev) begin
                check({tag, " hold valid"}, 64'(out_valid), 64'd1);
                check({tag, " hold data"}, 64'({ovf, cout, sum}), 64'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check({tag, " unexpected result"}, 64'(got), 64'(n_ops + 1));
                end else begin
                    exp_r = exp_q.pop_front();
                    check({tag, " result"}, 64'({ovf, cout, sum}), 64'(exp_r));
                end
                got++;
            end
            stalled_prev = out_valid && !out_ready;
            held = {ovf, cout, sum};
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_op(a, b, cin, sub));
                sent++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check({tag, " count"}, 64'(got), 64'(n_ops));
        if (exp_cycles > 0) check({tag, " throughput cycles"}, 64'(cyc), 64'(exp_cycles));
    endtask

    initial begin
        int stale;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset sum", 64'(sum), 64'd0);
        check("reset cout", 64'(cout), 64'd0);
        check("reset ovf", 64'(ovf), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        single_op("wrap",      32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        single_op("sub 5-7",   32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        single_op("sub 7-5",   32'd7, 32'd5, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
        single_op("ovf add",   32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        single_op("ovf sub",   32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        single_op("cin",       32'd10, 32'd20, 1'b1, 1'b0, 32'd31, 1'b0, 1'b0);
        single_op("cin ign",   32'd10, 32'd3, 1'b1, 1'b1, 32'd7, 1'b1, 1'b0);
        single_op("slice c1",  32'h0000_00FF, 32'd1, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        single_op("slice c3",  32'h00FF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0);

        run_stream("bp", 10, 5, 8, 1'b0, 0);
        run_stream("full rate", 16, -1, -1, 1'b0, 20);

        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 32'(i + 1); b = 32'd100; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst sum", 64'(sum), 64'd0);
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) stale++;
            @(posedge clk); #1;
        end
        check("midrst stale results", 64'(stale), 64'd0);

        run_stream("random", 3000, -1, -1, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
